// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: command codes, command width
// and the sequencer state encoding.
package alu_pkg;

    localparam int CMD_W = 4;

    localparam logic [CMD_W-1:0] ADD  = 4'h0;
    localparam logic [CMD_W-1:0] INC  = 4'h1;
    localparam logic [CMD_W-1:0] SUB  = 4'h2;
    localparam logic [CMD_W-1:0] DEC  = 4'h3;
    localparam logic [CMD_W-1:0] MUL  = 4'h4;
    localparam logic [CMD_W-1:0] DIV  = 4'h5;
    localparam logic [CMD_W-1:0] SHL  = 4'h6;
    localparam logic [CMD_W-1:0] SHR  = 4'h7;
    localparam logic [CMD_W-1:0] AND  = 4'h8;
    localparam logic [CMD_W-1:0] OR   = 4'h9;
    localparam logic [CMD_W-1:0] INV  = 4'hA;
    localparam logic [CMD_W-1:0] NAND = 4'hB;
    localparam logic [CMD_W-1:0] NOR  = 4'hC;
    localparam logic [CMD_W-1:0] XOR  = 4'hD;
    localparam logic [CMD_W-1:0] XNOR = 4'hE;
    localparam logic [CMD_W-1:0] BUF  = 4'hF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO for packed {a, b, cmd} operations.
// Pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Issue stage for the 8-bit combinational ALU: buffers ops, runs them one at a
// time and holds each result for a valid/ready consumer. ALU_SEQ_FLAGS_EN adds res_zero/res_divz.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [CMD_W-1:0]  in_cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic              alu_en,
    input  logic [RES_W-1:0]  alu_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [CMD_W-1:0]  res_cmd
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              res_zero,
    output logic              res_divz
`endif
);

    localparam int OP_W = 2*DATA_W + CMD_W;

    logic [1:0]      state;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            div_zero;
    logic [OP_W-1:0] head;

    // rst_n gates in_ready so nothing is accepted while reset is held
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && ((state == S_IDLE) || (state == S_HOLD && res_ready));
    assign div_zero = (alu_cmd == DIV) && (alu_b == '0);
    assign alu_en   = (state == S_EXEC) && !div_zero;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_a, in_b, in_cmd}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cmd   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero  <= 1'b0;
            res_divz  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {alu_a, alu_b, alu_cmd} <= head;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // a suppressed divide leaves the ALU disabled, so dout is already 0
                    res_data  <= alu_dout;
                    res_cmd   <= alu_cmd;
                    res_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    res_zero  <= (alu_dout == '0);
                    res_divz  <= div_zero;
`endif
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            {alu_a, alu_b, alu_cmd} <= head;
                            state <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: a behavioural ALU drives alu_dout, and a queue of
// pushed ops predicts every accepted result in order.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] c;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [3:0]  in_cmd = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_en;
    logic [15:0] alu_dout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [3:0]  res_cmd;
`ifdef ALU_SEQ_FLAGS_EN
    logic        res_zero;
    logic        res_divz;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int last_acc = -1;
    bit stream_mode = 1'b0;
    op_t q[$];
    op_t op;
    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    logic [3:0]  pc = '0;

    always #5 clk = ~clk;

    alu_cmd_seq #(.DEPTH(DEPTH), .DATA_W(8), .RES_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cmd    (in_cmd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cmd   (alu_cmd),
        .alu_en    (alu_en),
        .alu_dout  (alu_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cmd   (res_cmd)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .res_zero  (res_zero),
        .res_divz  (res_divz)
`endif
    );

    // The attached ALU; an enabled divide by zero gives all-ones so a
    // missing suppression is visible.
    function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] c);
        case (c)
            ADD:  return {8'h00, a} + {8'h00, b};
            INC:  return {8'h00, a} + 16'd1;
            SUB:  return {8'h00, a} - {8'h00, b};
            DEC:  return {8'h00, a} - 16'd1;
            MUL:  return {8'h00, a} * {8'h00, b};
            DIV:  return (b == 8'd0) ? 16'hFFFF : {8'h00, a / b};
            SHL:  return {8'h00, a} << b[2:0];
            SHR:  return {8'h00, a >> b[2:0]};
            AND:  return {8'h00, a & b};
            OR:   return {8'h00, a | b};
            INV:  return {8'h00, ~a};
            NAND: return {8'h00, ~(a & b)};
            NOR:  return {8'h00, ~(a | b)};
            XOR:  return {8'h00, a ^ b};
            XNOR: return {8'h00, ~(a ^ b)};
            default: return {8'h00, a};
        endcase
    endfunction

    function automatic logic [15:0] exp_res(op_t o);
        return (o.c == DIV && o.b == 8'd0) ? 16'h0000 : alu_fn(o.a, o.b, o.c);
    endfunction

    always_comb alu_dout = alu_en ? alu_fn(alu_a, alu_b, alu_cmd) : 16'h0000;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the queue model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            pv = 1'b0;
            check("rst_ctl", {29'd0, alu_en, res_valid, in_ready}, 32'd0);
            check("rst_res", {12'd0, res_data, res_cmd}, 32'd0);
            check("rst_alu", {12'd0, alu_a, alu_b, alu_cmd}, 32'd0);
        end else begin
            if (pv && !pr) begin
                check("hold_valid", {31'd0, res_valid}, 32'd1);
                check("hold_data", {12'd0, res_cmd, res_data}, {12'd0, pc, pd});
            end
            if (alu_en)
                check("en_on_divz", {31'd0, (alu_cmd == DIV && alu_b == 8'd0)}, 32'd0);
            if (q.size() < DEPTH)
                check("in_ready_free", {31'd0, in_ready}, 32'd1);
            else if (q.size() == DEPTH + 1)
                check("in_ready_full", {31'd0, in_ready}, 32'd0);
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    check("spurious_result", {16'd0, res_data}, 32'hDEAD_0000);
                end else begin
                    op = q.pop_front();
                    check("res_data", {16'd0, res_data}, {16'd0, exp_res(op)});
                    check("res_cmd", {28'd0, res_cmd}, {28'd0, op.c});
`ifdef ALU_SEQ_FLAGS_EN
                    check("res_zero", {31'd0, res_zero}, {31'd0, exp_res(op) == 16'd0});
                    check("res_divz", {31'd0, res_divz}, {31'd0, (op.c == DIV && op.b == 8'd0)});
`endif
                    if (stream_mode && last_acc >= 0)
                        check("stream_gap", cyc - last_acc, 32'd2);
                    last_acc = cyc;
                    acc_cnt++;
                end
            end
            if (in_valid && in_ready)
                q.push_back('{a: in_a, b: in_b, c: in_cmd});
            pv = res_valid;
            pr = res_ready;
            pd = res_data;
            pc = res_cmd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until the handshake edge; returns at edge+1.
    task automatic push_op(logic [7:0] a, logic [7:0] b, logic [3:0] c);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cmd = c;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done)
            check("push_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(int budget);
        res_ready = 1'b1;
        for (int t = 0; t < budget && q.size() != 0; t++)
            tick();
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        int base;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single MUL: EXEC one cycle after the push, result the cycle after that
        res_ready = 1'b1;
        push_op(8'd12, 8'd10, MUL);
        check("mul_no_early_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check("mul_exec_en", {31'd0, alu_en}, 32'd1);
        check("mul_exec_ops", {12'd0, alu_a, alu_b, alu_cmd}, {12'd0, 8'd12, 8'd10, 4'h4});
        tick();
        check("mul_valid", {31'd0, res_valid}, 32'd1);
        check("mul_data", {16'd0, res_data}, 32'd120);
        check("mul_cmd", {28'd0, res_cmd}, 32'h4);
        repeat (3) tick();

        // back-pressure: one op in HOLD plus a full FIFO
        res_ready = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < 5; i++)
            push_op(8'(i * 17 + 3), 8'(i + 2), (i % 2 == 0) ? SUB : XOR);
        tick();
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        drain(40);
        check("bp_count", acc_cnt - base, 32'd5);
        repeat (2) tick();

        // divide by zero keeps the ALU disabled and yields zero
        push_op(8'd200, 8'd0, DIV);
        tick();
        check("divz_exec_cmd", {28'd0, alu_cmd}, 32'h5);
        check("divz_en_low", {31'd0, alu_en}, 32'd0);
        tick();
        check("divz_valid", {31'd0, res_valid}, 32'd1);
        check("divz_data", {16'd0, res_data}, 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
        check("divz_flag", {30'd0, res_divz, res_zero}, 32'd3);
`endif
        repeat (3) tick();

        // streaming ADDs: one result every two cycles
        stream_mode = 1'b1;
        last_acc = -1;
        base = acc_cnt;
        for (int i = 0; i < 8; i++)
            push_op(8'(i), 8'd1, ADD);
        drain(40);
        stream_mode = 1'b0;
        check("stream_count", acc_cnt - base, 32'd8);
        repeat (2) tick();

        // hold stability for 10 cycles without acceptance
        res_ready = 1'b0;
        push_op(8'd3, 8'd4, XOR);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_lit", {11'd0, res_valid, res_cmd, res_data}, {11'd0, 1'b1, 4'hD, 16'd7});
            tick();
        end
        drain(10);
        repeat (2) tick();

        // reset while an op executes with three more queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_op(8'(40 + i), 8'd5, ADD);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("mid_exec_en", {31'd0, alu_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {29'd0, alu_en, res_valid, in_ready}, 32'd0);
        check("mid_rst_data", {12'd0, res_data, res_cmd}, 32'd0);
        check("mid_rst_alu", {12'd0, alu_a, alu_b, alu_cmd}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_stale", {31'd0, res_valid}, 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 8'($urandom());
            in_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom());
            in_cmd    = 4'($urandom());
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
